// File: rtl/synaptic_current_integrator.sv
// Synaptic current integrator: accumulates weighted spike events over a timestep and,
// on tick, updates i_out = sat(i_out*decay) + sat(acc) before pulsing apply to the core.
module synaptic_current_integrator #(
    parameter int N  = 24,
    parameter int Q  = 8,
    parameter int CW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic signed [N-1:0] decay,
    input  logic                spike_valid,
    input  logic signed [N-1:0] spike_weight,
    output logic                spike_ready,
    output logic signed [N-1:0] i_out,
    output logic                apply,
    output logic [CW-1:0]       spike_count,
    output logic                overrun
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_SUM, S_APPLY} state_t;

    localparam logic signed [N-1:0] MAXV = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};

    state_t               state_q, state_d;
    logic signed [N-1:0]  acc_q, acc_d;
    logic signed [N-1:0]  i_q, i_d;
    logic signed [N-1:0]  prod_q, prod_d;
    logic signed [N-1:0]  decay_q, decay_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        scnt_q, scnt_d;
    logic                 overrun_q, overrun_d;

    // Overflow only possible when operands share a sign and the result sign differs.
    function automatic logic signed [N-1:0] sat_add(input logic signed [N-1:0] a,
                                                    input logic signed [N-1:0] b);
        logic signed [N-1:0] s;
        s = a + b;
        if ((a[N-1] == b[N-1]) && (s[N-1] != a[N-1]))
            sat_add = a[N-1] ? MINV : MAXV;
        else
            sat_add = s;
    endfunction

    // Full-width product, floor shift by Q, then clamp unless the top bits are pure sign.
    function automatic logic signed [N-1:0] sat_mul_q(input logic signed [N-1:0] a,
                                                      input logic signed [N-1:0] b);
        logic signed [2*N-1:0] p;
        logic signed [2*N-1:0] s;
        p = a * b;
        s = p >>> Q;
        if ((&s[2*N-1:N-1]) || !(|s[2*N-1:N-1]))
            sat_mul_q = s[N-1:0];
        else
            sat_mul_q = s[2*N-1] ? MINV : MAXV;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (tick) state_d = S_MUL;
            S_MUL:   state_d = S_SUM;
            S_SUM:   state_d = S_APPLY;
            S_APPLY: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        spike_ready = (state_q == S_IDLE);
        apply       = (state_q == S_APPLY);
    end

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        i_d       = i_q;
        prod_d    = prod_q;
        scnt_d    = scnt_q;
        decay_d   = decay_q;
        overrun_d = tick && (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                // A spike coinciding with tick still lands in this step's acc.
                if (spike_valid) begin
                    acc_d = sat_add(acc_q, spike_weight);
                    cnt_d = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
                end
                if (tick)
                    decay_d = decay;
            end
            S_MUL: prod_d = sat_mul_q(i_q, decay_q);
            S_SUM: begin
                i_d    = sat_add(prod_q, acc_q);
                scnt_d = cnt_q;
                acc_d  = '0;
                cnt_d  = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            i_q       <= '0;
            prod_q    <= '0;
            scnt_q    <= '0;
            decay_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            i_q       <= i_d;
            prod_q    <= prod_d;
            scnt_q    <= scnt_d;
            decay_q   <= decay_d;
            overrun_q <= overrun_d;
        end
    end

    assign i_out       = i_q;
    assign spike_count = scnt_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_synaptic_current_integrator.sv
// Directed bench for synaptic_current_integrator (N=24, Q=8) with hand-computed expectations.
module tb_synaptic_current_integrator;

    logic               clk;
    logic               rst;
    logic               tick;
    logic signed [23:0] decay;
    logic               spike_valid;
    logic signed [23:0] spike_weight;
    logic               spike_ready;
    logic signed [23:0] i_out;
    logic               apply;
    logic [7:0]         spike_count;
    logic               overrun;

    int total = 0;
    int bad   = 0;

    logic [3:0]  ap_tr;
    logic [3:0]  rdy_tr;
    logic [23:0] i_app;
    logic [7:0]  cnt_app;

    synaptic_current_integrator #(.N(24), .Q(8), .CW(8)) dut (
        .clk(clk), .rst(rst), .tick(tick), .decay(decay),
        .spike_valid(spike_valid), .spike_weight(spike_weight),
        .spike_ready(spike_ready), .i_out(i_out), .apply(apply),
        .spike_count(spike_count), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called 1 time unit after an edge while idle; records samples at T+k for k=0..3.
    task automatic run_tick(input logic signed [23:0] d);
        tick = 1'b1;
        decay = d;
        @(posedge clk); #1;
        tick = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            ap_tr[k]  = apply;
            rdy_tr[k] = spike_ready;
            if (k == 2) i_app = i_out;
        end
        cnt_app = spike_count;
    endtask

    task automatic send_spike(input logic signed [23:0] w);
        spike_valid  = 1'b1;
        spike_weight = w;
        @(posedge clk); #1;
        spike_valid  = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        #1;
        total++; if (i_out !== 24'h000000) begin bad++; $display("FAIL reset_i_out got=%h want=000000", i_out); end
        total++; if (apply !== 1'b0) begin bad++; $display("FAIL reset_apply got=%b want=0", apply); end
        total++; if (spike_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", spike_ready); end
        total++; if (spike_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", spike_count); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        send_spike(24'h000100);
        send_spike(24'h000080);
        run_tick(24'h000080);
        total++; if (ap_tr !== 4'b0100) begin bad++; $display("FAIL basic_apply_timing got=%b want=0100", ap_tr); end
        total++; if (i_app !== 24'h000180) begin bad++; $display("FAIL basic_i_out got=%h want=000180", i_app); end
        total++; if (cnt_app !== 8'd2) begin bad++; $display("FAIL basic_count got=%0d want=2", cnt_app); end
        total++; if (rdy_tr !== 4'b1000) begin bad++; $display("FAIL basic_ready_trace got=%b want=1000", rdy_tr); end
        run_tick(24'h000080);
        total++; if (i_app !== 24'h0000C0) begin bad++; $display("FAIL basic_decay_i_out got=%h want=0000c0", i_app); end
        total++; if (cnt_app !== 8'd0) begin bad++; $display("FAIL basic_decay_count got=%0d want=0", cnt_app); end
        total++; if (ap_tr !== 4'b0100) begin bad++; $display("FAIL basic_apply_timing2 got=%b want=0100", ap_tr); end
        // i_out must hold between steps.
        repeat (3) @(posedge clk); #1;
        total++; if (i_out !== 24'h0000C0) begin bad++; $display("FAIL basic_hold got=%h want=0000c0", i_out); end
    endtask

    task automatic test_saturation;
        run_tick(24'h000000);
        total++; if (i_app !== 24'h000000) begin bad++; $display("FAIL sat_clear got=%h want=000000", i_app); end
        send_spike(24'h7FFF00);
        send_spike(24'h000200);
        run_tick(24'h000000);
        total++; if (i_app !== 24'h7FFFFF) begin bad++; $display("FAIL sat_acc_pos got=%h want=7fffff", i_app); end
        send_spike(24'h800100);
        send_spike(24'hFFFE00);
        run_tick(24'h000000);
        total++; if (i_app !== 24'h800000) begin bad++; $display("FAIL sat_acc_neg got=%h want=800000", i_app); end
        send_spike(24'h500000);
        run_tick(24'h000000);
        total++; if (i_app !== 24'h500000) begin bad++; $display("FAIL sat_load got=%h want=500000", i_app); end
        run_tick(24'h000200);
        total++; if (i_app !== 24'h7FFFFF) begin bad++; $display("FAIL sat_mul_pos got=%h want=7fffff", i_app); end
        run_tick(24'hFFFE00);
        total++; if (i_app !== 24'h800000) begin bad++; $display("FAIL sat_mul_neg got=%h want=800000", i_app); end
    endtask

    task automatic test_neg_rounding;
        run_tick(24'h000000);
        send_spike(24'hFFFFFF);
        run_tick(24'h000000);
        total++; if (i_app !== 24'hFFFFFF) begin bad++; $display("FAIL round_load got=%h want=ffffff", i_app); end
        run_tick(24'h000080);
        total++; if (i_app !== 24'hFFFFFF) begin bad++; $display("FAIL round_floor got=%h want=ffffff", i_app); end
    endtask

    task automatic test_backpressure;
        run_tick(24'h000000);
        tick = 1'b1;
        decay = 24'h000000;
        @(posedge clk); #1;
        tick = 1'b0;
        spike_valid = 1'b1;
        spike_weight = 24'h000010;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            rdy_tr[k] = spike_ready;
            if (k == 2) i_app = i_out;
        end
        total++; if (rdy_tr !== 4'b1000) begin bad++; $display("FAIL bp_ready_trace got=%b want=1000", rdy_tr); end
        total++; if (spike_count !== 8'd0) begin bad++; $display("FAIL bp_count_this got=%0d want=0", spike_count); end
        total++; if (i_app !== 24'h000000) begin bad++; $display("FAIL bp_i_this got=%h want=000000", i_app); end
        @(posedge clk); #1;
        spike_valid = 1'b0;
        run_tick(24'h000000);
        total++; if (i_app !== 24'h000010) begin bad++; $display("FAIL bp_i_next got=%h want=000010", i_app); end
        total++; if (cnt_app !== 8'd1) begin bad++; $display("FAIL bp_count_next got=%0d want=1", cnt_app); end
    endtask

    task automatic test_overrun;
        tick = 1'b1;
        decay = 24'h000100;
        @(posedge clk); #1;
        tick = 1'b0;
        @(posedge clk); #1;
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse got=%b want=1", overrun); end
        total++; if (apply !== 1'b1) begin bad++; $display("FAIL ovr_apply got=%b want=1", apply); end
        total++; if (i_out !== 24'h000010) begin bad++; $display("FAIL ovr_i_out got=%h want=000010", i_out); end
        @(posedge clk); #1;
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_one_cycle got=%b want=0", overrun); end
        total++; if (apply !== 1'b0) begin bad++; $display("FAIL ovr_apply_end got=%b want=0", apply); end
        @(posedge clk); #1;
        total++; if (apply !== 1'b0) begin bad++; $display("FAIL ovr_no_extra_apply got=%b want=0", apply); end
        total++; if (spike_ready !== 1'b1) begin bad++; $display("FAIL ovr_idle got=%b want=1", spike_ready); end
    endtask

    task automatic test_simultaneous;
        spike_valid = 1'b1;
        spike_weight = 24'h000020;
        tick = 1'b1;
        decay = 24'h000100;
        @(posedge clk); #1;
        spike_valid = 1'b0;
        tick = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if (i_out !== 24'h000030) begin bad++; $display("FAIL simul_i_out got=%h want=000030", i_out); end
        @(posedge clk); #1;
        total++; if (spike_count !== 8'd1) begin bad++; $display("FAIL simul_count got=%0d want=1", spike_count); end
    endtask

    task automatic test_abort;
        send_spike(24'h000040);
        tick = 1'b1;
        decay = 24'h000100;
        @(posedge clk); #1;
        tick = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++; if (i_out !== 24'h000000) begin bad++; $display("FAIL abort_i_out got=%h want=000000", i_out); end
        total++; if (spike_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", spike_ready); end
        @(posedge clk); #1;
        total++; if (apply !== 1'b0) begin bad++; $display("FAIL abort_apply1 got=%b want=0", apply); end
        @(posedge clk); #1;
        total++; if (apply !== 1'b0) begin bad++; $display("FAIL abort_apply2 got=%b want=0", apply); end
        rst = 1'b0;
        run_tick(24'h000100);
        total++; if (i_app !== 24'h000000) begin bad++; $display("FAIL abort_acc_cleared got=%h want=000000", i_app); end
        total++; if (cnt_app !== 8'd0) begin bad++; $display("FAIL abort_count got=%0d want=0", cnt_app); end
        send_spike(24'h000100);
        run_tick(24'h000100);
        total++; if (i_app !== 24'h000100) begin bad++; $display("FAIL abort_resume got=%h want=000100", i_app); end
        total++; if (ap_tr !== 4'b0100) begin bad++; $display("FAIL abort_resume_apply got=%b want=0100", ap_tr); end
    endtask

    initial begin
        rst = 1'b0;
        tick = 1'b0;
        decay = '0;
        spike_valid = 1'b0;
        spike_weight = '0;
        test_reset();
        test_basic();
        test_saturation();
        test_neg_rounding();
        test_backpressure();
        test_overrun();
        test_simultaneous();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/synaptic_current_integrator.md
Name: synaptic_current_integrator

Overview:
- Upstream stage of izhikevich_core. Accepts weighted presynaptic spike events through a valid/ready handshake and accumulates them over one timestep.
- On each timestep tick it computes i_next = sat(i*decay) + sat(acc), a first-order exponential synaptic current in signed Q fixed point.
- It then drives the core's i input with the result and issues a one-cycle apply pulse.

Parameters:
- N, 24, total signed fixed-point width, matches core.
- Q, 8, fractional bits; 1.0 = 1<<Q.
- CW, 8, width of per-step spike counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- tick  input  1  start-of-timestep strobe, one cycle.
- decay  input  N  signed Q multiplier applied to i each step (e.g. 1 - step/tau); sampled on accepted tick.
- spike_valid  input  1  presynaptic event present.
- spike_weight  input  N  signed Q weight of event.
- spike_ready  output  1  event accepted when valid&ready at posedge.
- i_out  output  N  synaptic current, to core i.
- apply  output  1  one-cycle pulse, to core apply.
- spike_count  output  CW  events accepted in last completed step.
- overrun  output  1  one-cycle pulse, tick arrived while busy.

Behaviour:
- Reset (async, any state): state=IDLE, acc=0, i_out=0, prod=0, cnt=0, spike_count=0, apply=0, overrun=0, decay_r=0. Reset mid-step aborts with no apply pulse.
- FSM states IDLE -> MUL -> SUM -> APPLY -> IDLE, one cycle each except IDLE.
- IDLE:
  - spike_ready=1.
  - Accepted event: acc <= sat(acc + spike_weight); cnt <= cnt + 1, saturating at 2^CW-1.
  - tick: decay_r <= decay; go MUL.
  - Spike and tick in same cycle: the spike counts toward the current step.
- MUL: prod <= sat(asr(i_out * decay_r, Q)).
  - Full 2N-bit signed product, arithmetic shift right by Q (floor toward -inf).
  - Saturate to N bits.
- SUM:
  - i_out <= sat(prod + acc).
  - spike_count <= cnt.
  - acc <= 0; cnt <= 0.
- APPLY: apply=1 for exactly this cycle; i_out is already stable (updated at end of SUM); return to IDLE.
- Latency: tick accepted at edge T; i_out new at T+2, apply high during cycle T+2..T+3; core samples both at edge T+3. Next tick accepted from IDLE at T+3 onward.
- spike_ready=0 in MUL, SUM and APPLY. Events held by the producer are not lost, only stalled.
- Tick in MUL, SUM or APPLY is ignored and overrun pulses high for one cycle. State and values are unaffected.
- Saturation everywhere: clamp to [-(2^(N-1)), 2^(N-1)-1], i.e. 0x800000..0x7FFFFF for N=24.
- Overflow is detected from operand and result sign bits; no wrap-around is permitted.
- All outputs are registered; apply and spike_ready decode from state registers only.
- i_out holds between steps. With no tick, i_out never changes and acc keeps accumulating.

Test Plan (N=24, Q=8):
- Reset: assert rst mid-cycle with no clock edge -> immediately i_out=0x000000, apply=0, spike_ready=1, spike_count=0, overrun=0.
- Basic step: decay=0x000080 (0.5), spikes 0x000100 then 0x000080, tick -> apply high exactly 3 edges after tick edge, i_out=0x000180, spike_count=2. Second tick with no spikes -> i_out=0x0000C0, spike_count=0.
- Saturation:
  - acc at 0x7FFF00 plus spike 0x000200 -> acc 0x7FFFFF; tick with i_out=0, decay=0 -> i_out=0x7FFFFF.
  - Negative: spikes 0x800100 + 0xFFFE00 -> i_out=0x800000.
  - decay=0x000200 (2.0) with i_out=0x500000 -> prod 0x7FFFFF.
- Negative rounding: i_out=0xFFFFFF (-1/256), decay=0x000080, no spikes -> i_out=0xFFFFFF (floor).
- Backpressure and overrun:
  - spike_valid held high across a tick -> spike_ready low for 3 cycles; the held event is accepted on return to IDLE and appears in the next step's count.
  - tick during SUM -> overrun one cycle, no extra apply.
- Simultaneous and abort:
  - Spike and tick on the same edge -> spike included in this step's i_out.
  - rst asserted while in MUL -> no apply pulse, i_out=0, acc=0; normal operation resumes after deassert.
